// File: rtl/pc_update_unit_if.sv
// rtl/pc_update_unit_if.sv - update-request and PC-register bus between control FSM and pc_update_unit
interface pc_update_unit_if;
  logic        upd_req;
  logic [2:0]  op;
  logic        br_taken;
  logic [15:0] imm;
  logic [15:0] pc_cur;
  logic        pc_we;
  logic [15:0] pc_next;
  logic        done;
  logic        busy;

  modport master (
    output upd_req, op, br_taken, imm, pc_cur,
    input  pc_we, pc_next, done, busy
  );

  modport slave (
    input  upd_req, op, br_taken, imm, pc_cur,
    output pc_we, pc_next, done, busy
  );
endinterface

// File: rtl/pc_update_unit.sv
// rtl/pc_update_unit.sv - next-PC generator with circular return-address stack and sticky error flags
module pc_update_unit #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pc_update_unit_if.slave          bus,
  output logic [$clog2(DEPTH):0]   ras_count,
  output logic                     err_ovf,
  output logic                     err_unf
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  localparam logic [2:0] OP_SEQ  = 3'd0;
  localparam logic [2:0] OP_BR   = 3'd1;
  localparam logic [2:0] OP_JMP  = 3'd2;
  localparam logic [2:0] OP_CALL = 3'd3;
  localparam logic [2:0] OP_RET  = 3'd4;

  typedef enum logic {IDLE, CALC} state_t;

  state_t        state_q, state_d;
  logic          accept, commit;
  logic [2:0]    op_q;
  logic          br_taken_q;
  logic [15:0]   imm_q;
  logic [15:0]   pc_q;
  logic [15:0]   pc_next_q;
  logic [PW-1:0] wr_ptr;
  logic [15:0]   mem [DEPTH];
  logic [15:0]   seq_pc;
  logic [15:0]   top;
  logic [15:0]   target;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.upd_req) begin
          accept  = 1'b1;
          state_d = CALC;
        end
      end
      CALC: begin
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Target is resolved at the accept edge so pc_next is a plain register in CALC.
  // The stack cannot change between accept and commit, so peeking the top here is safe.
  assign seq_pc = bus.pc_cur + 16'd1;
  assign top    = mem[wr_ptr - PW'(1)];

  always_comb begin
    target = seq_pc;
    case (bus.op)
      OP_BR:   target = bus.br_taken ? (bus.pc_cur + bus.imm) : seq_pc;
      OP_JMP:  target = bus.imm;
      OP_CALL: target = bus.imm;
      OP_RET:  target = (ras_count != '0) ? top : seq_pc;
      default: target = seq_pc;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q       <= OP_SEQ;
      br_taken_q <= 1'b0;
      imm_q      <= 16'h0000;
      pc_q       <= 16'h0000;
      pc_next_q  <= 16'h0000;
      wr_ptr     <= '0;
      ras_count  <= '0;
      err_ovf    <= 1'b0;
      err_unf    <= 1'b0;
    end else begin
      if (accept) begin
        op_q       <= bus.op;
        br_taken_q <= bus.br_taken;
        imm_q      <= bus.imm;
        pc_q       <= bus.pc_cur;
        pc_next_q  <= target;
      end
      if (commit) begin
        case (op_q)
          OP_CALL: begin
            wr_ptr <= wr_ptr + PW'(1);
            if (ras_count == FULL) err_ovf   <= 1'b1;
            else                   ras_count <= ras_count + CW'(1);
          end
          OP_RET: begin
            if (ras_count == '0) begin
              err_unf <= 1'b1;
            end else begin
              wr_ptr    <= wr_ptr - PW'(1);
              ras_count <= ras_count - CW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Full-stack push lands on the oldest slot, which is exactly the overwrite policy.
  always_ff @(posedge clk) begin
    if (commit && op_q == OP_CALL) mem[wr_ptr] <= pc_q + 16'd1;
  end

  assign bus.pc_we   = (state_q == CALC);
  assign bus.done    = (state_q == CALC);
  assign bus.busy    = (state_q == CALC);
  assign bus.pc_next = pc_next_q;

endmodule
